// File: rtl/posi_md_mode_fill_pkg.sv
// Shared definitions for the mode-position buffer controller:
// intra mode constants, CU size encodings, FSM state encoding and the
// CU-size to alignment-mask helper.
package posi_md_mode_fill_pkg;

  localparam logic [5:0] MODE_PLANAR = 6'd0;
  localparam logic [5:0] MODE_DC     = 6'd1;
  localparam logic [5:0] MODE_VER    = 6'd26;

  localparam logic [1:0] CU_8  = 2'd0;
  localparam logic [1:0] CU_16 = 2'd1;
  localparam logic [1:0] CU_32 = 2'd2;
  localparam logic [1:0] CU_64 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RD_L,
    ST_RD_T,
    ST_CALC,
    ST_OUT
  } state_t;

  // CU width in 8x8 units minus one; doubles as the alignment mask.
  function automatic logic [2:0] size_mask(input logic [1:0] sz);
    case (sz)
      CU_8:    return 3'd0;
      CU_16:   return 3'd1;
      CU_32:   return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/posi_md_mpm_derive.sv
// Combinational HEVC most-probable-mode list from left (A) and top (B)
// neighbour modes.
module posi_md_mpm_derive
  import posi_md_mode_fill_pkg::*;
#(
  parameter int DAT_WD = 6
) (
  input  logic [DAT_WD-1:0] a_i,
  input  logic [DAT_WD-1:0] b_i,
  output logic [DAT_WD-1:0] mpm0_o,
  output logic [DAT_WD-1:0] mpm1_o,
  output logic [DAT_WD-1:0] mpm2_o
);

  localparam int W = DAT_WD + 1;

  logic [W-1:0] a_p29;
  logic [W-1:0] a_m1;

  // Angular neighbours wrap inside the 32 angular modes; one spare bit
  // keeps A+29 from overflowing before the modulo.
  always_comb begin
    a_p29  = {1'b0, a_i} + W'(29);
    a_m1   = {1'b0, a_i} - W'(1);
    mpm0_o = a_i;
    mpm1_o = b_i;
    mpm2_o = DAT_WD'(MODE_VER);
    if (a_i == b_i) begin
      if (a_i < DAT_WD'(2)) begin
        mpm0_o = DAT_WD'(MODE_PLANAR);
        mpm1_o = DAT_WD'(MODE_DC);
        mpm2_o = DAT_WD'(MODE_VER);
      end else begin
        mpm0_o = a_i;
        mpm1_o = DAT_WD'(W'(2) + (a_p29 & W'(31)));
        mpm2_o = DAT_WD'(W'(2) + (a_m1 & W'(31)));
      end
    end else if (a_i != DAT_WD'(MODE_PLANAR) && b_i != DAT_WD'(MODE_PLANAR)) begin
      mpm2_o = DAT_WD'(MODE_PLANAR);
    end else if (a_i != DAT_WD'(MODE_DC) && b_i != DAT_WD'(MODE_DC)) begin
      mpm2_o = DAT_WD'(MODE_DC);
    end
  end

endmodule

// File: rtl/posi_md_mode_fill.sv
// Mode-position buffer controller in front of the 64x6 position/mode RAM.
// Fills every 8x8 slot of a decided CU with its mode, and reads the left
// and top neighbours of a queried CU (DC when outside the LCU).
// Optional feature macro: POSI_MD_MPM_EN adds the MPM derivation and the
// mpm0_o..mpm2_o ports; without it only mode_a_o/mode_b_o are produced.
// RAM enables are active low; read data returns the cycle after the read.
module posi_md_mode_fill
  import posi_md_mode_fill_pkg::*;
#(
  parameter int ADR_WD = 6,
  parameter int DAT_WD = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic              qry_i,
  input  logic [2:0]        cu_x_i,
  input  logic [2:0]        cu_y_i,
  input  logic [1:0]        cu_size_i,
  input  logic [DAT_WD-1:0] mode_i,
  output logic              ready_o,
  output logic              vld_o,
  output logic [DAT_WD-1:0] mode_a_o,
  output logic [DAT_WD-1:0] mode_b_o,
`ifdef POSI_MD_MPM_EN
  output logic [DAT_WD-1:0] mpm0_o,
  output logic [DAT_WD-1:0] mpm1_o,
  output logic [DAT_WD-1:0] mpm2_o,
`endif
  output logic [ADR_WD-1:0] adr_o,
  output logic              wr_ena_o,
  output logic [DAT_WD-1:0] wr_dat_o,
  output logic              rd_ena_o,
  input  logic [DAT_WD-1:0] rd_dat_i
);

  state_t            state_q;
  logic [2:0]        x_q, y_q, mask_q, r_q, c_q;
  logic              a_rd_q, b_rd_q;
  logic [DAT_WD-1:0] a_q;

  logic [2:0]        mask_in, fill_x, fill_y, r_nxt, c_nxt;
  logic              last_c, last_w;
  logic [5:0]        fill_adr0, fill_adr, left_adr, top_adr;
  logic [DAT_WD-1:0] a_nxt, b_nxt;

  assign ready_o = (state_q == ST_IDLE);

  // Fill walk (column fastest) and neighbour addresses, all as raster {y,x}.
  always_comb begin
    mask_in   = size_mask(cu_size_i);
    fill_x    = cu_x_i & ~mask_in;
    fill_y    = cu_y_i & ~mask_in;
    fill_adr0 = {fill_y, fill_x};
    last_c    = (c_q == mask_q);
    last_w    = last_c && (r_q == mask_q);
    c_nxt     = last_c ? 3'd0 : c_q + 3'd1;
    r_nxt     = last_c ? r_q + 3'd1 : r_q;
    fill_adr  = {y_q + r_nxt, x_q + c_nxt};
    left_adr  = {cu_y_i, cu_x_i - 3'd1};
    top_adr   = {y_q - 3'd1, x_q};
    a_nxt     = a_rd_q ? rd_dat_i : DAT_WD'(MODE_DC);
    b_nxt     = b_rd_q ? rd_dat_i : DAT_WD'(MODE_DC);
  end

`ifdef POSI_MD_MPM_EN
  logic [DAT_WD-1:0] mpm0_nxt, mpm1_nxt, mpm2_nxt;

  posi_md_mpm_derive #(.DAT_WD(DAT_WD)) u_mpm (
    .a_i    (a_q),
    .b_i    (b_nxt),
    .mpm0_o (mpm0_nxt),
    .mpm1_o (mpm1_nxt),
    .mpm2_o (mpm2_nxt)
  );

  // MPM list registered together with the neighbour modes on the result edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mpm0_o <= '0;
      mpm1_o <= '0;
      mpm2_o <= '0;
    end else if (state_q == ST_CALC) begin
      mpm0_o <= mpm0_nxt;
      mpm1_o <= mpm1_nxt;
      mpm2_o <= mpm2_nxt;
    end
  end
`endif

  // Main FSM with registered RAM controls. The result is registered on the
  // CALC exit edge so the output step coincides with the return to IDLE,
  // giving vld_o and ready_o in the same cycle; ST_OUT only recovers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      mask_q   <= '0;
      r_q      <= '0;
      c_q      <= '0;
      a_rd_q   <= 1'b0;
      b_rd_q   <= 1'b0;
      a_q      <= '0;
      vld_o    <= 1'b0;
      mode_a_o <= '0;
      mode_b_o <= '0;
      adr_o    <= '0;
      wr_ena_o <= 1'b1;
      wr_dat_o <= '0;
      rd_ena_o <= 1'b1;
    end else begin
      wr_ena_o <= 1'b1;
      rd_ena_o <= 1'b1;
      vld_o    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            x_q      <= fill_x;
            y_q      <= fill_y;
            mask_q   <= mask_in;
            r_q      <= '0;
            c_q      <= '0;
            wr_dat_o <= mode_i;
            wr_ena_o <= 1'b0;
            adr_o    <= ADR_WD'(fill_adr0);
            state_q  <= ST_FILL;
          end else if (qry_i) begin
            x_q     <= cu_x_i;
            y_q     <= cu_y_i;
            a_rd_q  <= (cu_x_i != 3'd0);
            if (cu_x_i != 3'd0) begin
              rd_ena_o <= 1'b0;
              adr_o    <= ADR_WD'(left_adr);
            end
            state_q <= ST_RD_L;
          end
        end
        ST_FILL: begin
          if (last_w) begin
            state_q <= ST_IDLE;
          end else begin
            r_q      <= r_nxt;
            c_q      <= c_nxt;
            wr_ena_o <= 1'b0;
            adr_o    <= ADR_WD'(fill_adr);
          end
        end
        ST_RD_L: begin
          b_rd_q <= (y_q != 3'd0);
          if (y_q != 3'd0) begin
            rd_ena_o <= 1'b0;
            adr_o    <= ADR_WD'(top_adr);
          end
          state_q <= ST_RD_T;
        end
        ST_RD_T: begin
          a_q     <= a_nxt;
          state_q <= ST_CALC;
        end
        ST_CALC: begin
          mode_a_o <= a_q;
          mode_b_o <= b_nxt;
          vld_o    <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
